// File: rtl/conv_pkg.sv
// Shared types and constants for the convolution sequencer: the FSM state enum,
// the pixel size and the default flattened-kernel width.
package conv_pkg;

    localparam int PX_SIZE             = 8;
    localparam int DEFAULT_KERNEL_BITS = 3 * 3 * 3 * PX_SIZE;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_LOAD,
        ST_SETTLE,
        ST_OUT
    } conv_state_t;

    // Channel index width; never narrower than one bit so a single channel still has a port.
    function automatic int ch_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/conv_settle_timer.sv
// Counts SETTLE_CYCLES cycles after a start pulse so the shared conv datapath can
// settle on a newly loaded kernel; done is high in the final counted cycle.
module conv_settle_timer #(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    output logic done
);

    localparam int               CNT_W    = 4;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(SETTLE_CYCLES - 1);

    logic [CNT_W-1:0] cnt_reg;
    logic             run_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_reg <= '0;
            run_reg <= 1'b0;
        end else if (start) begin
            cnt_reg <= '0;
            run_reg <= 1'b1;
        end else if (run_reg) begin
            if (cnt_reg == LAST_CNT) begin
                run_reg <= 1'b0;
            end else begin
                cnt_reg <= cnt_reg + CNT_W'(1);
            end
        end
    end

    assign done = run_reg && (cnt_reg == LAST_CNT);

endmodule

// File: rtl/conv_ctrl.sv
// Sequences one shared conv datapath over OUT_CHANNELS kernels per accepted image.
// Optional stall counter is enabled with the CONV_CTRL_PERF_EN macro.
module conv_ctrl
    import conv_pkg::*;
#(
    parameter int OUT_CHANNELS  = 4,
    parameter int KERNEL_BITS   = DEFAULT_KERNEL_BITS,
    parameter int SETTLE_CYCLES = 2,
    localparam int CH_W         = ch_width(OUT_CHANNELS)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic                   img_load,
    output logic                   kern_rd,
    output logic [CH_W-1:0]        kern_addr,
    input  logic [KERNEL_BITS-1:0] kern_rdata,
    output logic [KERNEL_BITS-1:0] kernel_q,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [CH_W-1:0]        out_ch,
    output logic                   out_last,
`ifdef CONV_CTRL_PERF_EN
    output logic                   busy,
    output logic [15:0]            stall_cnt
`else
    output logic                   busy
`endif
);

    localparam logic [CH_W-1:0] LAST_CH = CH_W'(OUT_CHANNELS - 1);

    conv_state_t            state_reg;
    logic                   in_ready_reg;
    logic                   img_load_reg;
    logic                   kern_rd_reg;
    logic [CH_W-1:0]        out_ch_reg;
    logic [KERNEL_BITS-1:0] kernel_q_reg;
    logic                   out_valid_reg;
    logic                   out_last_reg;
    logic                   busy_reg;

    logic accept;
    logic settle_start;
    logic settle_done;

    assign accept       = (state_reg == ST_IDLE) && in_valid && in_ready_reg;
    assign settle_start = (state_reg == ST_LOAD);

    conv_settle_timer #(
        .SETTLE_CYCLES(SETTLE_CYCLES)
    ) u_settle (
        .clk  (clk),
        .rst  (rst),
        .start(settle_start),
        .done (settle_done)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            in_ready_reg  <= 1'b0;
            img_load_reg  <= 1'b0;
            kern_rd_reg   <= 1'b0;
            out_ch_reg    <= '0;
            kernel_q_reg  <= '0;
            out_valid_reg <= 1'b0;
            out_last_reg  <= 1'b0;
            busy_reg      <= 1'b0;
        end else begin
            img_load_reg <= 1'b0;
            kern_rd_reg  <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    in_ready_reg <= 1'b1;
                    if (accept) begin
                        in_ready_reg <= 1'b0;
                        img_load_reg <= 1'b1;
                        kern_rd_reg  <= 1'b1;
                        out_ch_reg   <= '0;
                        busy_reg     <= 1'b1;
                        state_reg    <= ST_FETCH;
                    end
                end
                // kern_rd was raised on entry so it lines up with this cycle's kern_addr.
                ST_FETCH: begin
                    state_reg <= ST_LOAD;
                end
                ST_LOAD: begin
                    kernel_q_reg <= kern_rdata;
                    state_reg    <= ST_SETTLE;
                end
                ST_SETTLE: begin
                    if (settle_done) begin
                        out_valid_reg <= 1'b1;
                        out_last_reg  <= (out_ch_reg == LAST_CH);
                        state_reg     <= ST_OUT;
                    end
                end
                ST_OUT: begin
                    if (out_ready) begin
                        out_valid_reg <= 1'b0;
                        out_last_reg  <= 1'b0;
                        if (out_ch_reg == LAST_CH) begin
                            in_ready_reg <= 1'b1;
                            busy_reg     <= 1'b0;
                            state_reg    <= ST_IDLE;
                        end else begin
                            out_ch_reg  <= out_ch_reg + CH_W'(1);
                            kern_rd_reg <= 1'b1;
                            state_reg   <= ST_FETCH;
                        end
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_reg;
    assign img_load  = img_load_reg;
    assign kern_rd   = kern_rd_reg;
    assign kern_addr = out_ch_reg;
    assign kernel_q  = kernel_q_reg;
    assign out_valid = out_valid_reg;
    assign out_ch    = out_ch_reg;
    assign out_last  = out_last_reg;
    assign busy      = busy_reg;

`ifdef CONV_CTRL_PERF_EN
    logic [15:0] stall_cnt_reg;

    // Counts OUT cycles the consumer refused; restarts with every new image.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_reg <= '0;
        end else if (accept) begin
            stall_cnt_reg <= '0;
        end else if ((state_reg == ST_OUT) && !out_ready && (stall_cnt_reg != 16'hFFFF)) begin
            stall_cnt_reg <= stall_cnt_reg + 16'd1;
        end
    end

    assign stall_cnt = stall_cnt_reg;
`endif

endmodule

// File: tb/tb_conv_ctrl.sv
// Directed bench for conv_ctrl: a latency-counting reference model checked every cycle,
// plus literal timing/data expectations for the main scenarios and a single-channel instance.
module tb_conv_ctrl;

    localparam int N  = 4;
    localparam int S  = 2;
    localparam int KB = 216;

    localparam logic [KB-1:0] W1 = {{215{1'b1}}, 1'b0};
    localparam logic [KB-1:0] W2 = 216'd2;
    localparam logic [KB-1:0] W3 = {{214{1'b1}}, 2'b00};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          in_valid, out_ready;
    logic          in_ready, img_load, kern_rd, out_valid, out_last, busy;
    logic [1:0]    kern_addr, out_ch;
    logic [KB-1:0] kern_rdata, kernel_q;

    logic          in_valid1, out_ready1;
    logic          in_ready1, img_load1, kern_rd1, out_valid1, out_last1, busy1;
    logic [0:0]    kern_addr1, out_ch1;
    logic [KB-1:0] kern_rdata1, kernel_q1;
`ifdef CONV_CTRL_PERF_EN
    logic [15:0]   stall_cnt, stall_cnt1;
`endif

    conv_ctrl #(.OUT_CHANNELS(N), .KERNEL_BITS(KB), .SETTLE_CYCLES(S)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .img_load(img_load), .kern_rd(kern_rd), .kern_addr(kern_addr),
        .kern_rdata(kern_rdata), .kernel_q(kernel_q), .out_valid(out_valid),
        .out_ready(out_ready), .out_ch(out_ch), .out_last(out_last),
`ifdef CONV_CTRL_PERF_EN
        .busy(busy), .stall_cnt(stall_cnt)
`else
        .busy(busy)
`endif
    );

    conv_ctrl #(.OUT_CHANNELS(1), .KERNEL_BITS(KB), .SETTLE_CYCLES(S)) u_dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
        .img_load(img_load1), .kern_rd(kern_rd1), .kern_addr(kern_addr1),
        .kern_rdata(kern_rdata1), .kernel_q(kernel_q1), .out_valid(out_valid1),
        .out_ready(out_ready1), .out_ch(out_ch1), .out_last(out_last1),
`ifdef CONV_CTRL_PERF_EN
        .busy(busy1), .stall_cnt(stall_cnt1)
`else
        .busy(busy1)
`endif
    );

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [KB-1:0] word(input int k);
        logic [KB-1:0] w;
        w = {KB{k[0]}} ^ KB'(k);
        return w;
    endfunction

    // Kernel memory: one-cycle read latency.
    always @(posedge clk) begin
        if (kern_rd)  kern_rdata  <= word(int'(kern_addr));
        if (kern_rd1) kern_rdata1 <= word(int'(kern_addr1));
    end

    // Reference model: per channel, S+2 cycles of fetch/load/settle precede the output cycle.
    int cyc = 0;
    bit m_active, m_in_ready, m_img_load;
    int m_ch, m_cd, m_stall;
    int hs_cyc[$], hs_ch[$], acc_cyc[$], iload_cyc[$];
    bit hs_last[$];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_active   <= 1'b0;
            m_in_ready <= 1'b0;
            m_img_load <= 1'b0;
            m_ch       <= 0;
            m_cd       <= 0;
            m_stall    <= 0;
        end else begin
            if (out_valid && out_ready) begin
                hs_cyc.push_back(cyc);
                hs_ch.push_back(int'(out_ch));
                hs_last.push_back(out_last);
            end
            if (in_valid && in_ready) acc_cyc.push_back(cyc);
            if (img_load) iload_cyc.push_back(cyc);
            cyc <= cyc + 1;
            if (!m_active) begin
                m_img_load <= in_valid && m_in_ready;
                if (in_valid && m_in_ready) begin
                    m_active   <= 1'b1;
                    m_ch       <= 0;
                    m_cd       <= S + 2;
                    m_in_ready <= 1'b0;
                    m_stall    <= 0;
                end else begin
                    m_in_ready <= 1'b1;
                end
            end else begin
                m_img_load <= 1'b0;
                if (m_cd > 0) begin
                    m_cd <= m_cd - 1;
                end else if (out_ready) begin
                    if (m_ch == N - 1) begin
                        m_active   <= 1'b0;
                        m_in_ready <= 1'b1;
                    end else begin
                        m_ch <= m_ch + 1;
                        m_cd <= S + 2;
                    end
                end else if (m_stall < 65535) begin
                    m_stall <= m_stall + 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        bit exp_ov, exp_rd;
        exp_ov = m_active && (m_cd == 0);
        exp_rd = m_active && (m_cd == S + 2);
        chk("in_ready", in_ready, m_in_ready);
        chk("busy", busy, m_active);
        chk("out_valid", out_valid, exp_ov);
        chk("img_load", img_load, m_img_load);
        chk("kern_rd", kern_rd, exp_rd);
        if (exp_rd) chk("kern_addr", kern_addr, m_ch);
        if (exp_ov) begin
            chk("out_ch", out_ch, m_ch);
            chk("out_last", out_last, m_ch == N - 1);
            chk("kernel_q", kernel_q, word(m_ch));
        end
`ifdef CONV_CTRL_PERF_EN
        chk("stall_cnt", stall_cnt, m_stall);
`endif
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        int base, n1, l1;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        in_valid1 = 1'b0; out_ready1 = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_kernel_q", kernel_q, 0);
        chk("rst_busy", busy, 0);
        chk("rst_out_ch", out_ch, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("in_ready_after_rst", in_ready, 1);

        // Back-to-back images with in_valid held high.
        in_valid = 1'b1;
        for (int i = 0; i < 100 && iload_cyc.size() < 2; i++) @(negedge clk);
        chk("p1_timeout", iload_cyc.size() >= 2, 1);
        in_valid = 1'b0;
        chk("p1_hs_count", hs_cyc.size(), 4);
        chk("p1_first_latency", hs_cyc[0] - acc_cyc[0], 5);
        for (int i = 0; i < 4; i++) begin
            chk("p1_ch_seq", hs_ch[i], i);
            chk("p1_last", hs_last[i], i == 3);
            if (i > 0) chk("p1_interval", hs_cyc[i] - hs_cyc[i-1], 5);
        end
        chk("p1_reaccept", acc_cyc[1] - hs_cyc[3], 1);
        chk("p1_img_load", iload_cyc[1] - acc_cyc[1], 1);

        // Consumer stalls channel 1 for 7 cycles.
        for (int i = 0; i < 100 && !(out_valid && out_ch == 2'd1); i++) @(negedge clk);
        chk("p2_timeout", out_valid && out_ch == 2'd1, 1);
        out_ready = 1'b0;
        repeat (7) begin
            @(negedge clk);
            chk("p2_hold_valid", out_valid, 1);
            chk("p2_hold_ch", out_ch, 1);
            chk("p2_hold_kernel", kernel_q, W1);
        end
`ifdef CONV_CTRL_PERF_EN
        chk("p2_stall_cnt", stall_cnt, 7);
`endif
        out_ready = 1'b1;
        for (int i = 0; i < 50 && !(out_valid && out_ch == 2'd2); i++) @(negedge clk);
        chk("p2_kernel_ch2", kernel_q, W2);
        for (int i = 0; i < 50 && !(out_valid && out_ch == 2'd3); i++) @(negedge clk);
        chk("p2_kernel_ch3", kernel_q, W3);
        for (int i = 0; i < 50 && busy; i++) @(negedge clk);
        chk("p2_idle_timeout", busy, 0);

        // Reset during SETTLE of channel 2.
        base = hs_cyc.size();
        in_valid = 1'b1;
        for (int i = 0; i < 20 && !img_load; i++) @(negedge clk);
        in_valid = 1'b0;
        for (int i = 0; i < 50 && !(kern_rd && kern_addr == 2'd2); i++) @(negedge clk);
        chk("p3_fetch2_timeout", kern_rd && kern_addr == 2'd2, 1);
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("p3_rst_out_valid", out_valid, 0);
        chk("p3_rst_busy", busy, 0);
        chk("p3_rst_kernel_q", kernel_q, 0);
        chk("p3_rst_out_ch", out_ch, 0);
        chk("p3_rst_kern_rd", kern_rd, 0);
        chk("p3_rst_in_ready", in_ready, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("p3_in_ready_after", in_ready, 1);
        chk("p3_hs_before_abort", hs_cyc.size() - base, 2);

        // Fresh sequence after the aborted one.
        base = hs_cyc.size();
        in_valid = 1'b1;
        for (int i = 0; i < 20 && !img_load; i++) @(negedge clk);
        in_valid = 1'b0;
        for (int i = 0; i < 60 && busy; i++) @(negedge clk);
        chk("p4_idle_timeout", busy, 0);
        chk("p4_hs_count", hs_cyc.size() - base, 4);
        chk("p4_first_ch", hs_ch[base], 0);
        chk("p4_last_ch", hs_ch[base+3], 3);

        // Single-channel instance.
        n1 = 0; l1 = 0;
        in_valid1 = 1'b1;
        for (int i = 0; i < 20 && !img_load1; i++) @(negedge clk);
        chk("p5_img_load", img_load1, 1);
        in_valid1 = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (out_valid1) begin
                n1++;
                if (out_last1) l1++;
            end
        end
        chk("p5_valid_count", n1, 1);
        chk("p5_last_count", l1, 1);
        chk("p5_busy", busy1, 0);
        chk("p5_in_ready", in_ready1, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
